// File: rtl/digit_counter_chain.sv
// Cascade of NUM_DIGITS modulo counters sharing one prescaled tick, with set/run-up/run-down/pause control.
// Optional macro DIGIT_CHAIN_STOP_AT_ZERO_EN: down-count stops at all-zero and raises done.
module digit_counter_chain #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int PRESC_W    = 26
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] max_vals,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] set_vals,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          tick,
  output logic                          wrap,
  output logic                          running,
  output logic [PRESC_W-1:0]            presc_cnt
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
  ,
  output logic                          done
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SET, S_RUN} stateT;

  localparam logic [PRESC_W-1:0] TickLast = PRESC_W'(TICK_DIV - 1);

  stateT state, nextState;
  logic  dirDown, nextDir;
  logic  paused, nextPaused;

  logic                          stepNow;
  logic                          allZero;
  logic                          topWrap;
  logic                          stopHit;
  logic [NUM_DIGITS*DIGIT_W-1:0] stepDigits;
  logic [NUM_DIGITS*DIGIT_W-1:0] clampDigits;

  assign running = (state == S_RUN);
  assign stepNow = (state == S_RUN) && !paused && (presc_cnt == TickLast);

`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
  assign stopHit = stepNow && dirDown && allZero;
`else
  assign stopHit = 1'b0;
`endif

  // Ripple carry/borrow: every digit's next value is resolved in the step cycle.
  always_comb begin : stepLogic
    logic                en;
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] mx;
    logic [DIGIT_W-1:0] sv;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    en          = 1'b1;
    allZero     = 1'b1;
    topWrap     = 1'b0;
    stepDigits  = digits;
    clampDigits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur = digits[i*DIGIT_W +: DIGIT_W];
      mx  = max_vals[i*DIGIT_W +: DIGIT_W];
      sv  = set_vals[i*DIGIT_W +: DIGIT_W];
      clampDigits[i*DIGIT_W +: DIGIT_W] = (sv < mx) ? sv : mx;
      if (cur != '0) allZero = 1'b0;
      if (en) begin
        if (!dirDown) stepDigits[i*DIGIT_W +: DIGIT_W] = (cur >= mx) ? '0 : cur + DIGIT_W'(1);
        else          stepDigits[i*DIGIT_W +: DIGIT_W] = (cur == '0) ? mx : cur - DIGIT_W'(1);
      end
      if (i == NUM_DIGITS - 1) topWrap = en && (dirDown ? (cur == '0) : (cur >= mx));
      en = en && (dirDown ? (cur == '0) : (cur == mx));
    end
  end

  always_comb begin
    nextState  = state;
    nextDir    = dirDown;
    nextPaused = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode == 2'b01) nextState = S_SET;
        else if (mode[1]) begin
          nextState = S_RUN;
          nextDir   = mode[0];
        end
      end
      S_SET: begin
        if (mode == 2'b00) nextState = S_IDLE;
        else if (mode[1]) begin
          nextState = S_RUN;
          nextDir   = mode[0];
        end
      end
      S_RUN: begin
        if (mode == 2'b00)      nextState  = S_IDLE;
        else if (mode == 2'b01) nextPaused = 1'b1;
        else                    nextDir    = mode[0];
      end
      default: nextState = S_IDLE;
    endcase
    if (stopHit) begin
      nextState  = S_IDLE;
      nextPaused = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dirDown   <= 1'b0;
      paused    <= 1'b0;
      digits    <= '0;
      presc_cnt <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
      done      <= 1'b0;
`endif
    end else begin
      state   <= nextState;
      dirDown <= nextDir;
      paused  <= nextPaused;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      case (state)
        S_SET: begin
          digits    <= clampDigits;
          presc_cnt <= '0;
        end
        S_RUN: begin
          if (stepNow) begin
            presc_cnt <= '0;
            tick      <= 1'b1;
            if (!stopHit) begin
              digits <= stepDigits;
              wrap   <= topWrap;
            end
          end else if (!paused) begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
          end
        end
        default: ;
      endcase
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
      // Stop step forces S_IDLE, so the clear conditions below never coincide with it.
      if (stopHit) done <= 1'b1;
      if (state != S_SET && nextState == S_SET) done <= 1'b0;
      if (state != S_RUN && nextState == S_RUN && !nextDir) done <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_digit_counter_chain.sv
// Self-checking bench for digit_counter_chain: directed scenarios plus randomized mode sequences
// compared against a mixed-radix arithmetic model of the whole chain.
module tb_digit_counter_chain;

  localparam int ND = 2;
  localparam int DW = 4;
  localparam int TD = 4;
  localparam int PW = 3;
  localparam int VW = ND * DW;
  localparam int OW = VW + 3 + PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [VW-1:0] max_vals = '0;
  logic [VW-1:0] set_vals = '0;
  logic [VW-1:0] digits;
  logic          tick, wrap, running;
  logic [PW-1:0] presc_cnt;
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
  logic          done;
`endif

  digit_counter_chain #(.NUM_DIGITS(ND), .DIGIT_W(DW), .TICK_DIV(TD), .PRESC_W(PW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .max_vals(max_vals), .set_vals(set_vals),
    .digits(digits), .tick(tick), .wrap(wrap), .running(running), .presc_cnt(presc_cnt)
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
    , .done(done)
`endif
  );

  always #5 clk = ~clk;

  wire [OW-1:0] dutOut = {digits, tick, wrap, running, presc_cnt};

  int nCompared = 0;
  int nFailed   = 0;

  // Model: the chain is one mixed-radix number mValue with radix max_i+1 per digit.
  int mValue, mPresc;
  bit mInSet, mInRun, mPaused, mDown, mTick, mWrap, mDone;

  function automatic int total();
    int t = 1;
    for (int i = 0; i < ND; i++) t = t * (int'(max_vals[i*DW +: DW]) + 1);
    return t;
  endfunction

  function automatic logic [VW-1:0] to_digits(int v);
    logic [VW-1:0] d = '0;
    int r;
    for (int i = 0; i < ND; i++) begin
      r = int'(max_vals[i*DW +: DW]) + 1;
      d[i*DW +: DW] = DW'(v % r);
      v = v / r;
    end
    return d;
  endfunction

  function automatic int from_set();
    int v = 0;
    int s, m;
    for (int i = ND - 1; i >= 0; i--) begin
      s = int'(set_vals[i*DW +: DW]);
      m = int'(max_vals[i*DW +: DW]);
      v = v * (m + 1) + ((s < m) ? s : m);
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] model_out();
    return {to_digits(mValue), mTick, mWrap, mInRun, PW'(mPresc)};
  endfunction

  task automatic advance();
    bit stopped;
    @(posedge clk);
    stopped = 0;
    if (reset) begin
      {mInSet, mInRun, mPaused, mDown, mTick, mWrap, mDone} = '0;
      mValue = 0;
      mPresc = 0;
    end else begin
      mTick = 0;
      mWrap = 0;
      if (mInSet) begin
        mValue = from_set();
        mPresc = 0;
      end else if (mInRun && !mPaused) begin
        if (mPresc == TD - 1) begin
          mPresc = 0;
          mTick  = 1;
          if (!mDown) begin
            mWrap  = (mValue == total() - 1);
            mValue = (mValue + 1) % total();
          end else if (mValue == 0) begin
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
            stopped = 1;
            mDone   = 1;
`else
            mWrap  = 1;
            mValue = total() - 1;
`endif
          end else begin
            mValue = mValue - 1;
          end
        end else begin
          mPresc = mPresc + 1;
        end
      end
      if (stopped) begin
        mInRun  = 0;
        mPaused = 0;
      end else if (mInRun) begin
        if (mode == 2'b00) begin
          mInRun  = 0;
          mPaused = 0;
        end else if (mode == 2'b01) mPaused = 1;
        else begin
          mPaused = 0;
          mDown   = mode[0];
        end
      end else if (mode[1]) begin
        mInSet = 0;
        mInRun = 1;
        mDown  = mode[0];
        if (!mode[0]) mDone = 0;
      end else if (mode == 2'b01) begin
        if (!mInSet) mDone = 0;
        mInSet = 1;
      end else begin
        mInSet = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    mode     = 2'b10;
    max_vals = {4'd5, 4'd9};
    set_vals = {4'd3, 4'd3};
    advance();
    advance();
    nCompared++;
    if (digits !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || running !== 1'b0 || presc_cnt !== 3'd0) begin
      nFailed++;
      $display("FAIL reset_state: got %h want %h", dutOut, {8'h00, 6'b0});
    end
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
    nCompared++;
    if (done !== 1'b0) begin
      nFailed++;
      $display("FAIL reset_done: got %b want 0", done);
    end
`endif
    reset = 1'b0;
    mode  = 2'b00;
    advance();
    nCompared++;
    if (dutOut !== model_out()) begin
      nFailed++;
      $display("FAIL idle_hold: got %h want %h", dutOut, model_out());
    end
  endtask

  task automatic test_count_up();
    int ticks = 0;
    int wrapAt = -1;
    int wraps = 0;
    reset    = 1'b1;
    max_vals = {4'd5, 4'd9};
    advance();
    reset = 1'b0;
    mode  = 2'b10;
    for (int c = 0; c < 1 + 60 * TD + 2; c++) begin
      advance();
      nCompared++;
      if (dutOut !== model_out()) begin
        nFailed++;
        $display("FAIL count_up cycle %0d: got %h want %h", c, dutOut, model_out());
      end
      if (tick === 1'b1) begin
        ticks++;
        if (ticks == 10) begin
          nCompared++;
          if (digits !== 8'h10) begin
            nFailed++;
            $display("FAIL count_up_carry: got %h want 10", digits);
          end
        end
      end
      if (wrap === 1'b1) begin
        wraps++;
        wrapAt = ticks;
      end
    end
    nCompared++;
    if (wraps != 1 || wrapAt != 60) begin
      nFailed++;
      $display("FAIL count_up_wrap: got %0d wraps at tick %0d want 1 at tick 60", wraps, wrapAt);
    end
    mode = 2'b00;
    advance();
  endtask

  task automatic test_set_clamp();
    mode     = 2'b01;
    max_vals = {4'd5, 4'd9};
    set_vals = {4'd7, 4'd12};
    advance();
    advance();
    nCompared++;
    if (digits !== 8'h59 || presc_cnt !== 3'd0) begin
      nFailed++;
      $display("FAIL set_clamp: got %h/%0d want 59/0", digits, presc_cnt);
    end
    mode = 2'b00;
    advance();
    nCompared++;
    if (dutOut !== model_out() || digits !== 8'h59) begin
      nFailed++;
      $display("FAIL set_then_idle: got %h want %h", dutOut, model_out());
    end
  endtask

  task automatic test_count_down();
    int ticks = 0;
    mode     = 2'b01;
    set_vals = {4'd1, 4'd0};
    advance();
    advance();
    mode = 2'b11;
    for (int c = 0; c < 12 * TD && ticks < 11; c++) begin
      advance();
      nCompared++;
      if (dutOut !== model_out()) begin
        nFailed++;
        $display("FAIL count_down cycle %0d: got %h want %h", c, dutOut, model_out());
      end
      if (tick === 1'b1) begin
        ticks++;
        if (ticks == 1) begin
          nCompared++;
          if (digits !== 8'h09) begin
            nFailed++;
            $display("FAIL down_borrow: got %h want 09", digits);
          end
        end
`ifndef DIGIT_CHAIN_STOP_AT_ZERO_EN
        if (ticks == 11) begin
          nCompared++;
          if (digits !== 8'h59 || wrap !== 1'b1) begin
            nFailed++;
            $display("FAIL down_wrap: got %h wrap=%b want 59 wrap=1", digits, wrap);
          end
        end
`endif
      end
    end
    nCompared++;
    if (ticks < 11) begin
      nFailed++;
      $display("FAIL down_timeout: got %0d ticks want 11", ticks);
    end
    mode = 2'b00;
    advance();
  endtask

  task automatic test_pause();
    logic [VW-1:0] held;
    int waitCnt;
    bit found = 0;
    reset    = 1'b1;
    max_vals = {4'd5, 4'd9};
    advance();
    reset = 1'b0;
    mode  = 2'b10;
    for (int c = 0; c < 3 * TD && !found; c++) begin
      advance();
      if (presc_cnt === 3'd2 && c > TD) found = 1;
    end
    nCompared++;
    if (!found) begin
      nFailed++;
      $display("FAIL pause_setup: got no presc_cnt=2 want presc_cnt=2");
    end
    held = to_digits(mValue);
    mode = 2'b01;
    for (int c = 0; c < 10; c++) begin
      advance();
      nCompared++;
      if (tick !== 1'b0 || digits !== held || dutOut !== model_out()) begin
        nFailed++;
        $display("FAIL pause cycle %0d: got %h want %h", c, dutOut, model_out());
      end
    end
    mode    = 2'b10;
    waitCnt = 0;
    for (int c = 0; c < 2 * TD && waitCnt == 0; c++) begin
      advance();
      if (tick === 1'b1) waitCnt = c + 1;
    end
    nCompared++;
    if (waitCnt != 2) begin
      nFailed++;
      $display("FAIL pause_resume: got tick after %0d cycles want 2", waitCnt);
    end
  endtask

  task automatic test_reset_on_step();
    bit found = 0;
    mode = 2'b10;
    for (int c = 0; c < 4 * TD && !found; c++) begin
      advance();
      if (presc_cnt === 3'd3 && c > TD) found = 1;
    end
    nCompared++;
    if (!found || digits === 8'h00) begin
      nFailed++;
      $display("FAIL reset_step_setup: got %h want nonzero digits at presc 3", dutOut);
    end
    reset = 1'b1;
    advance();
    nCompared++;
    if (digits !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || running !== 1'b0) begin
      nFailed++;
      $display("FAIL reset_on_step: got %h want %h", dutOut, {8'h00, 6'b0});
    end
    reset = 1'b0;
    mode  = 2'b00;
    advance();
  endtask

`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
  task automatic test_stop_at_zero();
    int ticks = 0;
    max_vals = {4'd5, 4'd9};
    set_vals = {4'd0, 4'd2};
    mode     = 2'b01;
    advance();
    advance();
    mode = 2'b11;
    for (int c = 0; c < 4 * TD && ticks < 3; c++) begin
      advance();
      if (tick === 1'b1) begin
        ticks++;
        nCompared++;
        if (ticks == 3 && (done !== 1'b1 || digits !== 8'h00 || running !== 1'b0 || wrap !== 1'b0)) begin
          nFailed++;
          $display("FAIL stop_at_zero: got %h done=%b want 00 run=0 wrap=0 done=1", digits, done);
        end else if (ticks < 3 && (digits !== 8'(3 - ticks - 1) || done !== 1'b0)) begin
          nFailed++;
          $display("FAIL stop_count: got %h want %0d", digits, 2 - ticks);
        end
      end
    end
    nCompared++;
    if (ticks != 3) begin
      nFailed++;
      $display("FAIL stop_timeout: got %0d ticks want 3", ticks);
    end
    mode = 2'b00;
    advance();
  endtask
`endif

  task automatic test_random();
    int hold;
    for (int p = 0; p < 3; p++) begin
      reset = 1'b1;
      for (int i = 0; i < ND; i++) max_vals[i*DW +: DW] = DW'($urandom_range(0, 9));
      advance();
      reset = 1'b0;
      for (int s = 0; s < 120; s++) begin
        mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) set_vals = VW'($urandom);
        hold = $urandom_range(1, 10);
        for (int c = 0; c < hold; c++) begin
          advance();
          nCompared++;
          if (dutOut !== model_out()) begin
            nFailed++;
            $display("FAIL random p%0d s%0d: got %h want %h", p, s, dutOut, model_out());
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_set_clamp();
    test_count_down();
    test_pause();
    test_reset_on_step();
`ifdef DIGIT_CHAIN_STOP_AT_ZERO_EN
    test_stop_at_zero();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
